// File: rtl/quad_osc_pkg.sv
// rtl/quad_osc_pkg.sv - shared state type, width helper and result rounding for the quadrature oscillator
package quad_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } osc_state_t;

  typedef struct packed {
    logic        sat;
    logic [63:0] value;
  } round_t;

  function automatic int prod_width(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

  // Round half-up at frac_w, then optionally clamp to the signed data_w range.
  function automatic round_t round_reduce(input logic signed [63:0] sum, input int frac_w,
                                          input int data_w, input bit sat_en);
    logic signed [63:0] rnd;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    round_t r;
    rnd     = (sum + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    hi      = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (data_w - 1));
    r.sat   = 1'b0;
    r.value = rnd;
    if (sat_en && (rnd > hi)) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (sat_en && (rnd < lo)) begin
      r.sat   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_osc_rotate_pipe.sv
// rtl/quad_osc_rotate_pipe.sv - two-stage coupled-form rotation datapath holding the c/s state
// QUAD_OSC_SAT_EN selects clamping instead of wrapping in the result reduction
module quad_osc_rotate_pipe
  import quad_osc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int PROD_W = DATA_W + COEF_W + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seed,
  input  logic signed [DATA_W-1:0] seed_amp,
  input  logic                     launch,
  input  logic signed [COEF_W-1:0] coef_cos,
  input  logic signed [COEF_W-1:0] coef_sin,
  output logic                     busy,
  output logic signed [DATA_W-1:0] q_cos,
  output logic signed [DATA_W-1:0] q_sin,
  output logic                     q_valid,
  output logic signed [PROD_W-1:0] q_prod_1,
  output logic signed [PROD_W-1:0] q_prod_2,
  output logic                     sat_hit
);

  localparam int MUL_W = DATA_W + COEF_W;
`ifdef QUAD_OSC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                     v1;
  logic signed [MUL_W-1:0]  p_cc;
  logic signed [MUL_W-1:0]  p_ss;
  logic signed [MUL_W-1:0]  p_cs;
  logic signed [MUL_W-1:0]  p_sc;
  logic signed [PROD_W-1:0] sum_1;
  logic signed [PROD_W-1:0] sum_2;
  round_t                   rnd_1;
  round_t                   rnd_2;
  logic                     unused_hi;

  assign busy = v1;

  // Stage 1 always multiplies the current state, so q_cos/q_sin double as c/s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      p_cc <= '0;
      p_ss <= '0;
      p_cs <= '0;
      p_sc <= '0;
    end else begin
      v1 <= launch;
      if (launch) begin
        p_cc <= MUL_W'(coef_cos) * MUL_W'(q_cos);
        p_ss <= MUL_W'(coef_sin) * MUL_W'(q_sin);
        p_cs <= MUL_W'(coef_cos) * MUL_W'(q_sin);
        p_sc <= MUL_W'(coef_sin) * MUL_W'(q_cos);
      end
    end
  end

  always_comb begin
    sum_1 = PROD_W'(p_cc) - PROD_W'(p_ss);
    sum_2 = PROD_W'(p_cs) + PROD_W'(p_sc);
    rnd_1 = round_reduce(64'(sum_1), FRAC_W, DATA_W, SAT_EN);
    rnd_2 = round_reduce(64'(sum_2), FRAC_W, DATA_W, SAT_EN);
  end

  assign unused_hi = &{1'b0, rnd_1.value[63:DATA_W], rnd_2.value[63:DATA_W]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_cos    <= '0;
      q_sin    <= '0;
      q_valid  <= 1'b0;
      q_prod_1 <= '0;
      q_prod_2 <= '0;
      sat_hit  <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      sat_hit <= 1'b0;
      if (seed) begin
        q_cos   <= seed_amp;
        q_sin   <= '0;
        q_valid <= 1'b1;
      end else if (v1) begin
        q_prod_1 <= sum_1;
        q_prod_2 <= sum_2;
        q_cos    <= rnd_1.value[DATA_W-1:0];
        q_sin    <= rnd_2.value[DATA_W-1:0];
        q_valid  <= 1'b1;
        sat_hit  <= rnd_1.sat | rnd_2.sat;
      end
    end
  end

endmodule

// File: rtl/quad_rotation_oscillator.sv
// rtl/quad_rotation_oscillator.sv - quadrature recursive oscillator: start/stop FSM, config latch, flags
// QUAD_OSC_SAT_EN enables result clamping and the sticky sat_seen flag
module quad_rotation_oscillator
  import quad_osc_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int COEF_W = 16,
  parameter  int FRAC_W = 14,
  localparam int PROD_W = prod_width(DATA_W, COEF_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic signed [COEF_W-1:0] cfg_cos,
  input  logic signed [COEF_W-1:0] cfg_sin,
  input  logic signed [DATA_W-1:0] cfg_amp,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     sample_en,
  output logic signed [DATA_W-1:0] q_cos,
  output logic signed [DATA_W-1:0] q_sin,
  output logic                     q_valid,
  output logic signed [PROD_W-1:0] q_prod_1,
  output logic signed [PROD_W-1:0] q_prod_2,
  output logic                     busy,
  output logic                     overrun,
  output logic                     sat_seen
);

  osc_state_t               state;
  logic signed [COEF_W-1:0] coef_cos;
  logic signed [COEF_W-1:0] coef_sin;
  logic signed [DATA_W-1:0] coef_amp;
  logic                     coef_loaded;
  logic                     seed;
  logic                     launch;
  logic                     drop;
  logic                     pipe_busy;
  logic                     sat_hit;

  // A concurrent load takes priority over start; stop takes priority over a strobe.
  assign seed   = (state == ST_IDLE) && start && coef_loaded && !cfg_valid;
  assign launch = (state == ST_RUN) && sample_en && !stop && !pipe_busy;
  assign drop   = (state == ST_RUN) && sample_en && !stop && pipe_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cfg_ready   <= 1'b0;
      busy        <= 1'b0;
      coef_cos    <= '0;
      coef_sin    <= '0;
      coef_amp    <= '0;
      coef_loaded <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            coef_cos    <= cfg_cos;
            coef_sin    <= cfg_sin;
            coef_amp    <= cfg_amp;
            coef_loaded <= 1'b1;
          end else if (seed) begin
            state     <= ST_RUN;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            overrun   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            if (pipe_busy) begin
              state <= ST_DRAIN;
            end else begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              cfg_ready <= 1'b1;
            end
          end else if (drop) begin
            overrun <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!pipe_busy) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  quad_osc_rotate_pipe #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC_W (FRAC_W),
    .PROD_W (PROD_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .seed     (seed),
    .seed_amp (coef_amp),
    .launch   (launch),
    .coef_cos (coef_cos),
    .coef_sin (coef_sin),
    .busy     (pipe_busy),
    .q_cos    (q_cos),
    .q_sin    (q_sin),
    .q_valid  (q_valid),
    .q_prod_1 (q_prod_1),
    .q_prod_2 (q_prod_2),
    .sat_hit  (sat_hit)
  );

`ifdef QUAD_OSC_SAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_seen <= 1'b0;
    end else if (seed) begin
      sat_seen <= 1'b0;
    end else if (sat_hit) begin
      sat_seen <= 1'b1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_hit;
  assign sat_seen   = 1'b0;
`endif

endmodule

// File: tb/tb_quad_rotation_oscillator.sv
// tb/tb_quad_rotation_oscillator.sv - directed self-checking bench for quad_rotation_oscillator
module tb_quad_rotation_oscillator;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic signed [15:0] cfg_cos;
  logic signed [15:0] cfg_sin;
  logic signed [15:0] cfg_amp;
  logic               start;
  logic               stop;
  logic               sample_en;
  logic signed [15:0] q_cos;
  logic signed [15:0] q_sin;
  logic               q_valid;
  logic signed [32:0] q_prod_1;
  logic signed [32:0] q_prod_2;
  logic               busy;
  logic               overrun;
  logic               sat_seen;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  quad_rotation_oscillator dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_cos   (cfg_cos),
    .cfg_sin   (cfg_sin),
    .cfg_amp   (cfg_amp),
    .start     (start),
    .stop      (stop),
    .sample_en (sample_en),
    .q_cos     (q_cos),
    .q_sin     (q_sin),
    .q_valid   (q_valid),
    .q_prod_1  (q_prod_1),
    .q_prod_2  (q_prod_2),
    .busy      (busy),
    .overrun   (overrun),
    .sat_seen  (sat_seen)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int c, input int s, input int a);
    int k = 0;
    while (!cfg_ready && k < 10) begin
      step();
      k++;
    end
    chk("load_ready", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_cos   = 16'(c);
    cfg_sin   = 16'(s);
    cfg_amp   = 16'(a);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start(input string tag, input int amp);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_seed_valid"}, q_valid, 1);
    chk({tag, "_seed_cos"}, q_cos, amp);
    chk({tag, "_seed_sin"}, q_sin, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk({tag, "_stop_busy"}, busy, 0);
    chk({tag, "_stop_ready"}, cfg_ready, 1);
  endtask

  // One strobe; result must appear exactly two cycles later, then idle to a 4-cycle spacing.
  task automatic strobe(input string tag, input int exp_c, input int exp_s);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    chk({tag, "_early"}, q_valid, 0);
    step();
    chk({tag, "_valid"}, q_valid, 1);
    chk({tag, "_cos"}, q_cos, exp_c);
    chk({tag, "_sin"}, q_sin, exp_s);
    step(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv;
    reset = 1'b1; cfg_valid = 1'b0; cfg_cos = '0; cfg_sin = '0; cfg_amp = '0;
    start = 1'b0; stop = 1'b0; sample_en = 1'b0;
    step(2);
    chk("rst_valid", q_valid, 0);
    chk("rst_cos", q_cos, 0);
    chk("rst_prod1", q_prod_1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    step();
    chk("rel_ready", cfg_ready, 1);

    // start without any loaded coefficients
    start = 1'b1;
    step();
    start = 1'b0;
    chk("noload_busy", busy, 0);
    chk("noload_valid", q_valid, 0);

    // identity rotation
    load(16384, 0, 12000);
    do_start("id", 12000);
    for (int i = 0; i < 5; i++) strobe("id", 12000, 0);
    chk("id_prod1", q_prod_1, 64'sd196608000);
    chk("id_prod2", q_prod_2, 0);
    do_stop("id");

    // quarter turn
    load(0, 16384, 8192);
    do_start("qt", 8192);
    strobe("qt1", 0, 8192);
    chk("qt1_prod2", q_prod_2, 64'sd134217728);
    chk("qt1_prod1", q_prod_1, 0);
    strobe("qt2", -8192, 0);
    strobe("qt3", 0, -8192);
    strobe("qt4", 8192, 0);
    do_stop("qt");

    // gain above one
    load(16384, 16384, 30000);
    do_start("gn", 30000);
    strobe("gn1", 30000, 30000);
    chk("gn1_sat", sat_seen, 0);
`ifdef QUAD_OSC_SAT_EN
    strobe("gn2", 0, 32767);
    chk("gn2_sat", sat_seen, 1);
`else
    strobe("gn2", 0, -5536);
    chk("gn2_sat", sat_seen, 0);
`endif
    chk("gn2_prod2", q_prod_2, 64'sd983040000);
    do_stop("gn");

    // overrun on back-to-back strobes
    load(16384, 0, 12000);
    do_start("ov", 12000);
    chk("ov_sat_cleared", sat_seen, 0);
    sample_en = 1'b1;
    step(2);
    sample_en = 1'b0;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      if (q_valid) nv++;
      step();
    end
    chk("ov_valid_count", nv, 1);
    chk("ov_flag", overrun, 1);
    do_stop("ov");
    chk("ov_sticky", overrun, 1);
    do_start("ov2", 12000);
    chk("ov_cleared", overrun, 0);

    // stop one cycle after a strobe drains the update
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("drain_valid", q_valid, 1);
    chk("drain_busy", busy, 1);
    chk("drain_cos", q_cos, 12000);
    step();
    chk("drain_idle_busy", busy, 0);
    chk("drain_idle_ready", cfg_ready, 1);
    chk("drain_idle_valid", q_valid, 0);

    // start together with a load: load wins
    cfg_valid = 1'b1; start = 1'b1;
    cfg_cos = 16'sd0; cfg_sin = 16'sd16384; cfg_amp = 16'sd8192;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk("cfgst_busy", busy, 0);
    chk("cfgst_valid", q_valid, 0);
    chk("cfgst_hold_cos", q_cos, 12000);
    do_start("cfgst", 8192);
    strobe("cfgst1", 0, 8192);
    do_stop("cfgst");

    // strobe in IDLE is ignored
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    step();
    chk("idle_strobe_valid", q_valid, 0);
    chk("idle_strobe_overrun", overrun, 0);

    // reset with an update in flight
    do_start("rm", 8192);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("rm_valid", q_valid, 0);
    chk("rm_cos", q_cos, 0);
    chk("rm_sin", q_sin, 0);
    chk("rm_prod2", q_prod_2, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ready", cfg_ready, 0);
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (q_valid) nv++;
    end
    chk("rm_no_valid", nv, 0);
    reset = 1'b0;
    step();
    chk("rm_rel_ready", cfg_ready, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rm_unloaded_busy", busy, 0);
    chk("rm_unloaded_valid", q_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
